// File: rtl/spi_multi_master.sv
// Shared SPI engine on the ZX-Uno register bus: NUM_CS devices, programmable divider,
// all four CPOL/CPHA modes, busy flag and overrun detection.
module spi_multi_master #(
    parameter int          NUM_CS    = 2,
    parameter logic [7:0]  ADDR_DATA = 8'h02,
    parameter logic [7:0]  ADDR_CTRL = 8'h03,
    parameter logic [7:0]  ADDR_DIV  = 8'h04,
    parameter logic [7:0]  ADDR_STAT = 8'h05,
    parameter logic [7:0]  DIV_RESET = 8'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        addr,
    input  logic              ior,
    input  logic              iow,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              oe_n,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic [NUM_CS-1:0] spi_miso,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d, div_q, div_d, rx_q, rx_d;
    logic [7:0]  tx_q, tx_d, rsh_q, rsh_d, dcnt_q, dcnt_d;
    logic [3:0]  hp_q, hp_d;
    logic        sclk_q, sclk_d, mosi_q, mosi_d, ovr_q, ovr_d, pend_q, pend_d;
    logic        ior_q, iow_q;

    logic        ior_rise, iow_rise, sel_data, sel_ctrl, sel_div, sel_stat;
    logic        rx_block, start, ovr_set, miso_bit;
    logic [7:0]  tx_new;

    assign ior_rise = ior & ~ior_q;
    assign iow_rise = iow & ~iow_q;
    assign sel_data = (addr == ADDR_DATA);
    assign sel_ctrl = (addr == ADDR_CTRL);
    assign sel_div  = (addr == ADDR_DIV);
    assign sel_stat = (addr == ADDR_STAT);
    // A DATA read in progress freezes rx so the CPU sees a stable byte.
    assign rx_block = ior & sel_data;

    assign busy     = (state_q != IDLE);
    assign spi_clk  = sclk_q;
    assign spi_mosi = (state_q == IDLE) ? 1'b1 : mosi_q;
    assign oe_n     = ~(ior & (sel_data | sel_ctrl | sel_div | sel_stat));

    for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
        assign spi_cs_n[i] = ~(ctrl_q[7] && ctrl_q[2:0] == 3'(i));
    end

    always_comb begin
        miso_bit = 1'b1;
        for (int i = 0; i < NUM_CS; i++)
            if (ctrl_q[2:0] == 3'(i)) miso_bit = spi_miso[i];
    end

    always_comb begin
        dout = 8'hFF;
        if (!oe_n) begin
            if (sel_data)      dout = rx_q;
            else if (sel_ctrl) dout = ctrl_q;
            else if (sel_div)  dout = div_q;
            else               dout = {6'b0, ovr_q, busy};
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        rsh_d   = rsh_q;
        dcnt_d  = dcnt_q;
        hp_d    = hp_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
        start   = 1'b0;
        ovr_set = 1'b0;
        tx_new  = din;

        if (iow_rise) begin
            if (sel_data) begin
                if (state_q == IDLE) start = 1'b1;
                else                 ovr_set = 1'b1;
            end else if (sel_ctrl) begin
                if (state_q == IDLE) ctrl_d = din;
                else                 ovr_set = 1'b1;
            end else if (sel_div) begin
                if (state_q == IDLE) div_d = din;
                else                 ovr_set = 1'b1;
            end
        end
        if (ior_rise && sel_data) begin
            if (state_q == IDLE) begin
                start  = 1'b1;
                tx_new = 8'hFF;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (ior_rise && sel_stat) ovr_d = 1'b0;
        if (ovr_set)              ovr_d = 1'b1;

        if (pend_q && !rx_block) begin
            rx_d   = rsh_q;
            pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                sclk_d = ctrl_q[6];
                if (start) begin
                    state_d = SHIFT;
                    hp_d    = 4'd0;
                    dcnt_d  = 8'd0;
                    // CPHA=0 presents bit 7 immediately; CPHA=1 drives it on the leading edge.
                    tx_d    = ctrl_q[5] ? tx_new : {tx_new[6:0], 1'b0};
                    mosi_d  = ctrl_q[5] ? 1'b1 : tx_new[7];
                end
            end
            SHIFT: begin
                if (dcnt_q == div_q) begin
                    dcnt_d = 8'd0;
                    sclk_d = ~sclk_q;
                    hp_d   = hp_q + 4'd1;
                    // Even half-periods end on a leading edge.
                    if (~hp_q[0] ^ ctrl_q[5]) begin
                        rsh_d = {rsh_q[6:0], miso_bit};
                    end else begin
                        mosi_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (hp_q == 4'd15) state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (rx_block) pend_d = 1'b1;
                else          rx_d   = rsh_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= 8'h00;
            div_q   <= DIV_RESET;
            rx_q    <= 8'hFF;
            tx_q    <= 8'h00;
            rsh_q   <= 8'hFF;
            dcnt_q  <= 8'd0;
            hp_q    <= 4'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
            ior_q   <= 1'b0;
            iow_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            rsh_q   <= rsh_d;
            dcnt_q  <= dcnt_d;
            hp_q    <= hp_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
            ior_q   <= ior;
            iow_q   <= iow;
        end
    end
endmodule
